// File: rtl/bin_window_gen_pkg.sv
// Shared definitions for the binary window generator and the conv stage it feeds.
// Holds the one-hot state encoding and the default frame geometry.
package bin_window_gen_pkg;

    typedef enum logic [2:0] {
        S_FILL = 3'b001,
        S_EMIT = 3'b010,
        S_DONE = 3'b100
    } state_t;

    localparam int IMG_W_DEF = 12;
    localparam int IMG_H_DEF = 12;
    localparam int K_DEF     = 4;

endpackage

// File: rtl/bin_window_gen_window_mux.sv
// Combinational KxK window selection from a K-row line buffer at a given column.
// Bit r*K+c of win is rows[r][col+c]; columns past the row edge read as 0.
module window_mux #(
    parameter int IMG_W = 12,
    parameter int K     = 4,
    parameter int CW    = 4
) (
    input  logic [K-1:0][IMG_W-1:0] rows,
    input  logic [CW-1:0]           col,
    output logic [K*K-1:0]          win
);

    logic [K-1:0][IMG_W-1:0] shifted;

    // Right-shift each row so the window's leftmost column lands at bit 0.
    always_comb begin
        shifted = '0;
        win     = '0;
        for (int r = 0; r < K; r++) begin
            shifted[r]      = rows[r] >> col;
            win[r*K +: K]   = shifted[r][K-1:0];
        end
    end

endmodule

// File: rtl/bin_window_gen.sv
// Line-buffered KxK stride-1 window generator for a binarized feature map.
// Accepts one row per handshake and emits every window row-major with valid/ready.
module bin_window_gen
    import bin_window_gen_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [IMG_W-1:0] row_data,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [K*K-1:0]   win_data,
    output logic [3:0]       win_row,
    output logic [3:0]       win_col,
    output logic             frame_done
);

    localparam int OW  = IMG_W - K + 1;
    localparam int OH  = IMG_H - K + 1;
    localparam int RLW = $clog2(K + 1);

    localparam logic [RLW-1:0] RL_LAST = RLW'(K - 1);
    localparam logic [3:0]     COL_MAX = 4'(OW - 1);
    localparam logic [3:0]     ROW_MAX = 4'(OH - 1);

    state_t                  state;
    logic [RLW-1:0]          rows_loaded;
    logic [K-1:0][IMG_W-1:0] line_buf;

    // Window word is a pure function of the registered buffer and column.
    window_mux #(
        .IMG_W (IMG_W),
        .K     (K),
        .CW    (4)
    ) u_mux (
        .rows (line_buf),
        .col  (win_col),
        .win  (win_data)
    );

    // Frame FSM, line buffer shift and registered handshake outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_FILL;
            rows_loaded <= '0;
            line_buf    <= '0;
            win_row     <= 4'd0;
            win_col     <= 4'd0;
            win_valid   <= 1'b0;
            row_ready   <= 1'b1;
            frame_done  <= 1'b0;
        end else if (clr) begin
            state       <= S_FILL;
            rows_loaded <= '0;
            line_buf    <= '0;
            win_row     <= 4'd0;
            win_col     <= 4'd0;
            win_valid   <= 1'b0;
            row_ready   <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (row_valid) begin
                        // Oldest row sits in line_buf[0]; new row enters at the bottom.
                        line_buf    <= {row_data, line_buf[K-1:1]};
                        rows_loaded <= rows_loaded + RLW'(1);
                        if (rows_loaded == RL_LAST) begin
                            state     <= S_EMIT;
                            row_ready <= 1'b0;
                            win_valid <= 1'b1;
                        end else begin
                            state <= S_FILL;
                        end
                    end else begin
                        state <= S_FILL;
                    end
                end
                S_EMIT: begin
                    if (win_ready) begin
                        if (win_col < COL_MAX) begin
                            win_col <= win_col + 4'd1;
                        end else begin
                            win_col   <= 4'd0;
                            win_valid <= 1'b0;
                            if (win_row < ROW_MAX) begin
                                // Only one fresh row is needed to slide the buffer down.
                                win_row     <= win_row + 4'd1;
                                rows_loaded <= RL_LAST;
                                row_ready   <= 1'b1;
                                state       <= S_FILL;
                            end else begin
                                frame_done <= 1'b1;
                                state      <= S_DONE;
                            end
                        end
                    end else begin
                        state <= S_EMIT;
                    end
                end
                S_DONE: begin
                    frame_done  <= 1'b0;
                    win_row     <= 4'd0;
                    rows_loaded <= '0;
                    row_ready   <= 1'b1;
                    state       <= S_FILL;
                end
                default: begin
                    state       <= S_FILL;
                    rows_loaded <= '0;
                    win_row     <= 4'd0;
                    win_col     <= 4'd0;
                    win_valid   <= 1'b0;
                    row_ready   <= 1'b1;
                    frame_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_window_gen.sv
// Directed scoreboard bench for bin_window_gen: expected windows are queued as rows
// are accepted and compared when the DUT hands each window out.
module tb_bin_window_gen;

    localparam int W  = 12;
    localparam int H  = 12;
    localparam int KK = 4;
    localparam int NO = 15;

    logic          clk = 1'b0;
    logic          rstn, clr, row_valid, row_ready, win_valid, win_ready, frame_done;
    logic [W-1:0]  row_data;
    logic [15:0]   win_data;
    logic [3:0]    win_row, win_col;

    typedef struct packed {
        logic [3:0]  r;
        logic [3:0]  c;
        logic [15:0] d;
    } win_t;

    win_t         exp_q[$];
    logic [W-1:0] img [H];
    int           vectors     = 0;
    int           miscompares = 0;
    int           win_cnt     = 0;
    int           done_cnt    = 0;

    always #5 clk = ~clk;

    bin_window_gen dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    function automatic logic [15:0] ref_win(input int r0, input int c0);
        logic [15:0] w;
        logic [W-1:0] rowv;
        w = 16'h0000;
        for (int r = 0; r < KK; r++) begin
            rowv = img[r0 + r];
            for (int c = 0; c < KK; c++) w[r*KK + c] = rowv[c0 + c];
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {21'd0, win_valid, row_ready, frame_done, win_row, win_col},
              {21'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0});
    endtask

    task automatic set_checker();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 1'((r + c) & 1);
    endtask

    task automatic set_single(input int pr, input int pc);
        for (int r = 0; r < H; r++) img[r] = '0;
        img[pr][pc] = 1'b1;
    endtask

    // Drives one frame cycle by cycle; optional stall, clr abort, async reset.
    task automatic run_frame(input bit gaps, input int stall_r, input int stall_c,
                             input int abort_r, input int abort_c,
                             input int rst_at, input int done_at);
        int rows_sent  = 0;
        int iter       = 0;
        int stall_left = 3;
        bit fin        = 1'b0;
        win_t e;
        while (!fin) begin
            @(negedge clk);
            iter++;
            if (iter > 600) begin
                check("timeout", 32'd0, 32'd1);
                fin = 1'b1;
            end else if (iter == rst_at) begin
                row_valid = 1'b0;
                win_ready = 1'b0;
                #2 rstn = 1'b0;
                #1 check_reset_vals("async_rst");
                @(negedge clk);
                #2 rstn = 1'b1;
                exp_q.delete();
                fin = 1'b1;
            end else if (win_valid && int'(win_row) == abort_r && int'(win_col) == abort_c) begin
                clr       = 1'b1;
                row_valid = 1'b0;
                win_ready = 1'b0;
                @(negedge clk);
                check_reset_vals("clr");
                clr = 1'b0;
                exp_q.delete();
                fin = 1'b1;
            end else begin
                row_valid = (rows_sent < H) && (!gaps || (iter % 2 == 0));
                row_data  = (rows_sent < H) ? img[rows_sent] : '0;
                if (win_valid && int'(win_row) == stall_r && int'(win_col) == stall_c
                    && stall_left > 0) begin
                    win_ready = 1'b0;
                    stall_left--;
                    if (exp_q.size() > 0)
                        check("stall_hold", {8'd0, win_row, win_col, win_data}, {8'd0, exp_q[0]});
                    else
                        check("stall_no_exp", 32'd0, 32'd1);
                end else begin
                    win_ready = 1'b1;
                end
                if (row_valid && row_ready) begin
                    if (rows_sent >= KK - 1)
                        for (int c = 0; c <= W - KK; c++) begin
                            e.r = 4'(rows_sent - KK + 1);
                            e.c = 4'(c);
                            e.d = ref_win(rows_sent - KK + 1, c);
                            exp_q.push_back(e);
                        end
                    rows_sent++;
                end
                if (win_valid && win_ready) begin
                    win_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_win", 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("window", {8'd0, win_row, win_col, win_data}, {8'd0, e});
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                    if (done_at != 0) check("done_cycle", iter, done_at);
                    check("rows_consumed", rows_sent, H);
                    check("queue_drained", exp_q.size(), 0);
                    if (stall_r != NO) check("stall_seen", stall_left, 0);
                    fin = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rstn      = 1'b0;
        clr       = 1'b0;
        row_valid = 1'b0;
        win_ready = 1'b0;
        row_data  = '0;
        #12 rstn = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");

        // Checkerboard at full throughput.
        set_checker();
        win_cnt = 0; done_cnt = 0;
        run_frame(1'b0, NO, NO, NO, NO, 0, 94);
        check("cb_windows", win_cnt, 81);
        check("cb_done", done_cnt, 1);

        // Single pixel top-left, then bottom-right.
        set_single(0, 0);
        win_cnt = 0;
        run_frame(1'b0, NO, NO, NO, NO, 0, 94);
        check("px00_windows", win_cnt, 81);
        set_single(11, 11);
        win_cnt = 0;
        run_frame(1'b0, NO, NO, NO, NO, 0, 94);
        check("px1111_windows", win_cnt, 81);

        // Three-cycle stall at window (2,5).
        set_checker();
        win_cnt = 0;
        run_frame(1'b0, 2, 5, NO, NO, 0, 97);
        check("stall_windows", win_cnt, 81);

        // Row source valid only every other cycle.
        win_cnt = 0;
        run_frame(1'b1, NO, NO, NO, NO, 0, 0);
        check("gap_windows", win_cnt, 81);

        // clr at window (4,3), then a clean frame.
        run_frame(1'b0, NO, NO, 4, 3, 0, 0);
        win_cnt = 0;
        run_frame(1'b0, NO, NO, NO, NO, 0, 94);
        check("post_clr_windows", win_cnt, 81);

        // Async reset mid-frame, then two back-to-back frames.
        run_frame(1'b0, NO, NO, NO, NO, 40, 0);
        win_cnt = 0; done_cnt = 0;
        run_frame(1'b0, NO, NO, NO, NO, 0, 94);
        run_frame(1'b0, NO, NO, NO, NO, 0, 94);
        check("b2b_windows", win_cnt, 162);
        check("b2b_done", done_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
